// File: rtl/i2c_slave_regs.sv
// I2C target: 7-bit address match, 4-byte MSB-first write into rx_data,
// 4-byte MSB-first read from a tx_data snapshot. Open-drain SDA via sda_oe.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR  = 7'b0101010,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        rd_start,
  output logic        busy
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [31:0] word_q, word_d;
  logic [31:0] tx_sr_q, tx_sr_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  sent_q, sent_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rd_start_q, rd_start_d;

  // Synchronise the bus pins; reset to the idle-high bus level so no false edge follows reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      tx_sr_q    <= '0;
      byte_idx_q <= '0;
      sent_q     <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rd_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      tx_sr_q    <= tx_sr_d;
      byte_idx_q <= byte_idx_d;
      sent_q     <= sent_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rd_start_q <= rd_start_d;
    end
  end

  // Next-state: STOP/START override everything; otherwise sample on SCL rise, drive on SCL fall
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    word_d     = word_q;
    tx_sr_d    = tx_sr_q;
    byte_idx_d = byte_idx_q;
    sent_d     = sent_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rd_start_d = 1'b0;
    if (stop_det) begin
      state_d   = S_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      state_d   = S_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            if (shift_q[7:1] == SLAVE_ADDR) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shift_q[0];
              state_d  = S_ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              // tx_data is snapshotted here; the read in progress never sees later changes
              tx_sr_d    = tx_data;
              rd_start_d = 1'b1;
              sda_oe_d   = ~tx_data[31];
              bit_cnt_d  = 4'd1;
              sent_d     = '0;
              state_d    = S_TX;
            end else begin
              sda_oe_d   = 1'b0;
              byte_idx_d = '0;
              bit_cnt_d  = '0;
              state_d    = S_RX;
            end
          end
        end
        S_RX: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            state_d   = S_RX_ACK;
            // Bytes beyond the fourth are NACKed and dropped
            if (byte_idx_q < 3'd4) begin
              sda_oe_d = 1'b1;
              word_d   = {word_q[23:0], shift_q};
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        S_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            if (byte_idx_q == 3'd3) begin
              rx_data_d  = word_q;
              rx_valid_d = 1'b1;
            end
            if (byte_idx_q < 3'd4) byte_idx_d = byte_idx_q + 3'd1;
            state_d = S_RX;
          end
        end
        S_TX: begin
          // tx_sr_q[31] is the bit currently on the bus; bit_cnt_q counts bits driven so far
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              tx_sr_d   = tx_sr_q << 1;
              sent_d    = sent_q + 3'd1;
              bit_cnt_d = '0;
              state_d   = S_TX_ACK;
            end else if (bit_cnt_q == 4'd0) begin
              sda_oe_d  = ~tx_sr_q[31];
              bit_cnt_d = 4'd1;
            end else begin
              sda_oe_d  = ~tx_sr_q[30];
              tx_sr_d   = tx_sr_q << 1;
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_TX_ACK: begin
          // After the fourth byte stay released even on ACK so the master reads 0xFF
          if (scl_rise) begin
            if (!sda_s && sent_q < 3'd4) state_d = S_TX;
            else                         state_d = S_WAIT_STOP;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rd_start = rd_start_q;
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench: a bit-banged I2C master on an open-drain loopback bus.
module tb_i2c_slave_regs;
  localparam int Q = 8;  // clk cycles per SCL quarter period

  logic        clk = 1'b0;
  logic        rst;
  logic        scl;
  logic        sda_m;
  logic [31:0] tx_data;
  logic        sda_oe, rx_valid, rd_start, busy;
  logic [31:0] rx_data;
  wire         sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regs #(.SLAVE_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_start(rd_start), .busy(busy)
  );

  // Pulse monitor: counts pulses and flags any pulse longer than one clk or rx_valid/rd_start overlap
  int   rxv_cnt = 0, rds_cnt = 0, pulse_err = 0, oe_cnt = 0;
  logic rxv_p = 1'b0, rds_p = 1'b0;
  always @(negedge clk) begin
    if (rx_valid) rxv_cnt++;
    if (rd_start) rds_cnt++;
    if ((rx_valid && rxv_p) || (rd_start && rds_p) || (rx_valid && rd_start)) pulse_err++;
    if (sda_oe) oe_cnt++;
    rxv_p = rx_valid;
    rds_p = rd_start;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_start();
    sda_m = 1'b1; hold(Q); scl = 1'b1; hold(Q); sda_m = 1'b0; hold(Q); scl = 1'b0; hold(Q);
  endtask

  task automatic m_stop();
    sda_m = 1'b0; hold(Q); scl = 1'b1; hold(Q); sda_m = 1'b1; hold(Q);
  endtask

  task automatic m_bit(input logic b);
    sda_m = b; hold(Q); scl = 1'b1; hold(2*Q); scl = 1'b0; hold(Q);
  endtask

  task automatic m_ack_slot(output logic acked);
    sda_m = 1'b1; hold(Q); scl = 1'b1; hold(Q); acked = sda_oe; hold(Q); scl = 1'b0; hold(Q);
  endtask

  task automatic m_rbit(output logic b);
    sda_m = 1'b1; hold(Q); scl = 1'b1; hold(Q); b = sda_bus; hold(Q); scl = 1'b0; hold(Q);
  endtask

  task automatic m_wbyte(input logic [7:0] d, output logic acked);
    for (int i = 7; i >= 0; i--) m_bit(d[i]);
    m_ack_slot(acked);
  endtask

  task automatic m_rbyte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      m_rbit(b);
      d[i] = b;
    end
    m_bit(~ack);
  endtask

  typedef struct {
    logic [6:0]  addr;
    int          nbytes;   // bytes beyond 4 send 8'h99
    logic [31:0] data;
    logic [5:0]  ack_exp;  // bit i: expected ACK on slot i (slot 0 = address)
    int          rxv_exp;
    logic [31:0] rx_exp;
    logic        busy_exp;
  } wvec_t;

  wvec_t       tbl[5];
  wvec_t       v;
  logic        a;
  logic [7:0]  d, db;
  logic [31:0] w;
  int          rxv0, rds0, oe0;

  initial begin
    tbl[0] = '{7'h2A, 4, 32'hAABCCC0F, 6'b011111, 1, 32'hAABCCC0F, 1'b1};
    tbl[1] = '{7'h2B, 4, 32'h12345678, 6'b000000, 0, 32'hAABCCC0F, 1'b0};
    tbl[2] = '{7'h2A, 2, 32'hDEAD0000, 6'b000111, 0, 32'hAABCCC0F, 1'b1};
    tbl[3] = '{7'h2A, 5, 32'h11223344, 6'b011111, 1, 32'h11223344, 1'b1};
    tbl[4] = '{7'h6A, 1, 32'h5A000000, 6'b000000, 0, 32'h11223344, 1'b0};

    rst = 1'b1; scl = 1'b1; sda_m = 1'b1; tx_data = '0;
    hold(5);
    chk("reset sda_oe", {31'b0, sda_oe}, 32'd0);
    chk("reset rx_data", rx_data, 32'd0);
    chk("reset rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("reset rd_start", {31'b0, rd_start}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    hold(5);

    // Write transactions from the table
    for (int r = 0; r < 5; r++) begin
      v = tbl[r];
      rxv0 = rxv_cnt; oe0 = oe_cnt;
      m_start();
      m_wbyte({v.addr, 1'b0}, a);
      chk($sformatf("w%0d ack addr", r), {31'b0, a}, {31'b0, v.ack_exp[0]});
      chk($sformatf("w%0d busy mid", r), {31'b0, busy}, {31'b0, v.busy_exp});
      for (int b = 0; b < v.nbytes; b++) begin
        db = (b < 4) ? v.data[31-8*b -: 8] : 8'h99;
        m_wbyte(db, a);
        chk($sformatf("w%0d ack byte%0d", r, b), {31'b0, a}, {31'b0, v.ack_exp[b+1]});
      end
      m_stop();
      hold(4);
      chk($sformatf("w%0d rx_valid pulses", r), rxv_cnt - rxv0, v.rxv_exp);
      chk($sformatf("w%0d rx_data", r), rx_data, v.rx_exp);
      chk($sformatf("w%0d busy after stop", r), {31'b0, busy}, 32'd0);
      if (!v.busy_exp) chk($sformatf("w%0d sda_oe never set", r), oe_cnt - oe0, 32'd0);
    end

    // Read 0x2A, ACK three bytes, NACK the fourth; tx_data changes after the snapshot
    tx_data = 32'h12345678; rds0 = rds_cnt; rxv0 = rxv_cnt;
    m_start();
    m_wbyte({7'h2A, 1'b1}, a);
    chk("rd ack addr", {31'b0, a}, 32'd1);
    m_rbyte(1'b1, d); chk("rd byte0", {24'b0, d}, 32'h12);
    tx_data = 32'hFFFFFFFF;
    m_rbyte(1'b1, d); chk("rd byte1", {24'b0, d}, 32'h34);
    m_rbyte(1'b1, d); chk("rd byte2", {24'b0, d}, 32'h56);
    m_rbyte(1'b0, d); chk("rd byte3", {24'b0, d}, 32'h78);
    hold(2);
    chk("rd released after nack", {31'b0, sda_oe}, 32'd0);
    chk("rd busy before stop", {31'b0, busy}, 32'd1);
    chk("rd rd_start pulses", rds_cnt - rds0, 32'd1);
    m_stop(); hold(4);
    chk("rd busy after stop", {31'b0, busy}, 32'd0);
    chk("rd no rx_valid", rxv_cnt - rxv0, 32'd0);

    // Read with ACK on all four bytes: a fifth byte reads as 0xFF
    tx_data = 32'h0F1E2D3C;
    m_start();
    m_wbyte({7'h2A, 1'b1}, a);
    for (int b = 0; b < 4; b++) begin
      m_rbyte(1'b1, d);
      w[31-8*b -: 8] = d;
    end
    chk("rd5 word", w, 32'h0F1E2D3C);
    m_rbyte(1'b0, d); chk("rd5 fifth byte", {24'b0, d}, 32'hFF);
    m_stop(); hold(4);

    // One-byte write, repeated START, then read
    tx_data = 32'hCAFEF00D; rxv0 = rxv_cnt; rds0 = rds_cnt;
    m_start();
    m_wbyte({7'h2A, 1'b0}, a); chk("rs ack waddr", {31'b0, a}, 32'd1);
    m_wbyte(8'h77, a);         chk("rs ack wbyte", {31'b0, a}, 32'd1);
    m_start();
    m_wbyte({7'h2A, 1'b1}, a); chk("rs ack raddr", {31'b0, a}, 32'd1);
    for (int b = 0; b < 4; b++) begin
      m_rbyte(b < 3, d);
      w[31-8*b -: 8] = d;
    end
    chk("rs read word", w, 32'hCAFEF00D);
    m_stop(); hold(4);
    chk("rs no rx_valid", rxv_cnt - rxv0, 32'd0);
    chk("rs rd_start pulses", rds_cnt - rds0, 32'd1);
    chk("rs rx_data kept", rx_data, 32'h11223344);

    // Async reset while the target holds the ACK low
    m_start();
    for (int i = 7; i >= 0; i--) m_bit(i == 7 ? 1'b0 : ((8'h54 >> i) & 1));
    sda_m = 1'b1; hold(Q); scl = 1'b1; hold(Q);
    chk("rst ack held", {31'b0, sda_oe}, 32'd1);
    rst = 1'b1; #1;
    chk("rst sda_oe immediate", {31'b0, sda_oe}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst rx_data", rx_data, 32'd0);
    hold(2); scl = 1'b0; hold(Q);
    rst = 1'b0; scl = 1'b1; hold(Q);
    rxv0 = rxv_cnt;
    m_start();
    m_wbyte({7'h2A, 1'b0}, a); chk("post-rst ack addr", {31'b0, a}, 32'd1);
    for (int b = 0; b < 4; b++) begin
      db = 8'h0B << 0;
      w = 32'h0BADBEEF;
      m_wbyte(w[31-8*b -: 8], a);
      chk($sformatf("post-rst ack byte%0d", b), {31'b0, a}, 32'd1);
    end
    m_stop(); hold(4);
    chk("post-rst rx_data", rx_data, 32'h0BADBEEF);
    chk("post-rst rx_valid pulses", rxv_cnt - rxv0, 32'd1);

    chk("pulse width/overlap errors", pulse_err, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
